image_ram_arbiter: RTL and testbench

- Shares one single-port 784-byte image RAM (28x28, 8-bit pixels) between three requesters.
- Requesters: the VGA image-draw path (display read), the neural-net engine (pixel read), and the image loader (pixel write).
- Display reads have absolute priority because the pixel pipeline cannot stall. Loader and NN share the leftover slots round-robin.
- Read data is returned with a fixed, tagged latency, so every requester knows which returned word is its own.

---
 rtl/image_ram_pkg.sv | 26 ++
 rtl/image_ram_arbiter_rd_tag_pipe.sv | 73 +++++++
 rtl/image_ram_arbiter.sv | 154 +++++++++++++++
 tb/tb_image_ram_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_ram_pkg.sv
// Shared definitions for the image RAM arbiter.
//   - Image geometry: 28x28 8-bit pixels, so 784 words are addressable.
//   - Default address and data widths.
//   - tag_e: identifies who owns a read slot as it travels down the
//     read-latency pipeline.
//   - served_e: which of the two shared requesters (NN or loader) was
//     served last, for round-robin.
package image_ram_pkg;

    localparam int IMG_SIDE   = 28;
    localparam int IMG_WORDS  = IMG_SIDE * IMG_SIDE;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_NN   = 2'd2
    } tag_e;

    typedef enum logic {
        SRV_NN = 1'b0,
        SRV_WR = 1'b1
    } served_e;

endpackage

// File: rtl/image_ram_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: carries the owner tag of each RAM slot (plus a "return zero"
// flag for out-of-range NN reads) alongside the RAM read latency, so the
// valid pulse for a read lines up with the cycle its data sits on ram_rdata.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (clears all tags)
//   tag_in       owner of the slot being issued this cycle
//   zero_in      slot's read data must be presented as 0
//   disp_valid   registered: ram_rdata holds a display word this cycle
//   nn_rvalid    registered: ram_rdata holds the NN word this cycle
//   rd_zero      registered: the NN word of this cycle must be forced to 0
module rd_tag_pipe
    import image_ram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_e tag_in,
    input  logic zero_in,
    output logic disp_valid,
    output logic nn_rvalid,
    output logic rd_zero
);

    tag_e stage_tag_d  [RD_LAT];
    tag_e stage_tag_q  [RD_LAT];
    logic stage_zero_d [RD_LAT];
    logic stage_zero_q [RD_LAT];

    logic disp_valid_d, disp_valid_q;
    logic nn_rvalid_d,  nn_rvalid_q;
    logic rd_zero_d,    rd_zero_q;

    always_comb begin
        stage_tag_d[0]  = tag_in;
        stage_zero_d[0] = zero_in;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_tag_d[i]  = stage_tag_q[i-1];
            stage_zero_d[i] = stage_zero_q[i-1];
        end
        // The output flops are the final stage: stage 0 is loaded one cycle
        // after the request, the outputs RD_LAT cycles after that.
        disp_valid_d = (stage_tag_q[RD_LAT-1] == TAG_DISP);
        nn_rvalid_d  = (stage_tag_q[RD_LAT-1] == TAG_NN);
        rd_zero_d    = (stage_tag_q[RD_LAT-1] == TAG_NN) && stage_zero_q[RD_LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_tag_q[i]  <= TAG_NONE;
                stage_zero_q[i] <= 1'b0;
            end
            disp_valid_q <= 1'b0;
            nn_rvalid_q  <= 1'b0;
            rd_zero_q    <= 1'b0;
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_tag_q[i]  <= stage_tag_d[i];
                stage_zero_q[i] <= stage_zero_d[i];
            end
            disp_valid_q <= disp_valid_d;
            nn_rvalid_q  <= nn_rvalid_d;
            rd_zero_q    <= rd_zero_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign nn_rvalid  = nn_rvalid_q;
    assign rd_zero    = rd_zero_q;

endmodule

// File: rtl/image_ram_arbiter.sv
// image_ram_arbiter: shares one single-port 784-word image RAM between the
// display read path (absolute priority), the NN engine (reads) and the
// image loader (writes). NN and loader alternate round-robin on free slots.
//
// Ports:
//   CLOCK_50, RST_N             clock, asynchronous active-low reset
//   disp_en/disp_addr           display read request (may be high every cycle)
//   disp_valid                  ram_rdata holds a display word
//   nn_req/nn_addr, nn_gnt      NN read request (held until nn_gnt pulse)
//   nn_rvalid                   rd_data holds the NN word
//   wr_req/wr_addr/wr_data      loader write request (held until wr_gnt pulse)
//   wr_gnt                      write performed
//   err_addr/err_clr            sticky out-of-range flag and its clear
//   ram_addr/ram_we/ram_wdata   registered RAM command
//   ram_rdata                   RAM read data
//   rd_data                     ram_rdata, forced to 0 for out-of-range NN
//                               reads (a gate on the RAM's registered output)
module image_ram_arbiter
    import image_ram_pkg::tag_e, image_ram_pkg::TAG_NONE, image_ram_pkg::TAG_DISP,
           image_ram_pkg::TAG_NN, image_ram_pkg::served_e, image_ram_pkg::SRV_NN,
           image_ram_pkg::SRV_WR;
#(
    parameter int ADDR_W    = image_ram_pkg::ADDR_W_DEF,
    parameter int DATA_W    = image_ram_pkg::DATA_W_DEF,
    parameter int RD_LAT    = 1,
    parameter int IMG_WORDS = image_ram_pkg::IMG_WORDS
) (
    input  logic              CLOCK_50,
    input  logic              RST_N,
    input  logic              disp_en,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    input  logic              nn_req,
    input  logic [ADDR_W-1:0] nn_addr,
    output logic              nn_gnt,
    output logic              nn_rvalid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              err_addr,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(IMG_WORDS);

    logic [ADDR_W-1:0] ram_addr_d,  ram_addr_q;
    logic              ram_we_d,    ram_we_q;
    logic [DATA_W-1:0] ram_wdata_d, ram_wdata_q;
    logic              nn_gnt_d,    nn_gnt_q;
    logic              wr_gnt_d,    wr_gnt_q;
    logic              err_d,       err_q;
    served_e           last_d,      last_q;

    tag_e tag_d;
    logic zero_d;
    logic err_set;
    logic nn_elig, wr_elig;
    logic disp_bad, nn_bad, wr_bad;
    logic rd_zero;

    always_comb begin
        // A request whose grant is showing this cycle is the one just served;
        // masking it prevents a second grant for the same held request.
        nn_elig  = nn_req && !nn_gnt_q;
        wr_elig  = wr_req && !wr_gnt_q;
        disp_bad = (disp_addr >= ADDR_LIMIT);
        nn_bad   = (nn_addr   >= ADDR_LIMIT);
        wr_bad   = (wr_addr   >= ADDR_LIMIT);

        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        nn_gnt_d    = 1'b0;
        wr_gnt_d    = 1'b0;
        last_d      = last_q;
        tag_d       = TAG_NONE;
        zero_d      = 1'b0;
        err_set     = 1'b0;

        if (disp_en) begin
            // A bad display address consumes the slot but never touches the RAM.
            if (disp_bad) begin
                err_set = 1'b1;
            end else begin
                ram_addr_d = disp_addr;
                tag_d      = TAG_DISP;
            end
        end else if (nn_elig && (!wr_elig || last_q == SRV_WR)) begin
            ram_addr_d = nn_addr;
            nn_gnt_d   = 1'b1;
            last_d     = SRV_NN;
            tag_d      = TAG_NN;
            zero_d     = nn_bad;
            err_set    = nn_bad;
        end else if (wr_elig) begin
            ram_addr_d  = wr_addr;
            ram_we_d    = !wr_bad;
            ram_wdata_d = wr_data;
            wr_gnt_d    = 1'b1;
            last_d      = SRV_WR;
            err_set     = wr_bad;
        end

        // Set has priority over clear.
        err_d = err_set || (err_q && !err_clr);
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            nn_gnt_q    <= 1'b0;
            wr_gnt_q    <= 1'b0;
            err_q       <= 1'b0;
            last_q      <= SRV_WR;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            nn_gnt_q    <= nn_gnt_d;
            wr_gnt_q    <= wr_gnt_d;
            err_q       <= err_d;
            last_q      <= last_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk        (CLOCK_50),
        .rst_n      (RST_N),
        .tag_in     (tag_d),
        .zero_in    (zero_d),
        .disp_valid (disp_valid),
        .nn_rvalid  (nn_rvalid),
        .rd_zero    (rd_zero)
    );

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign nn_gnt    = nn_gnt_q;
    assign wr_gnt    = wr_gnt_q;
    assign err_addr  = err_q;
    assign rd_data   = rd_zero ? '0 : ram_rdata;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Bench for image_ram_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share
// one stimulus stream, each with its own RAM model. A slot-level reference
// model decides who owns each cycle, keeps a reference image, and schedules
// the expected valid pulses and words by absolute cycle number.
module tb_image_ram_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int NCYC  = 2048;
    localparam int LIMIT = 784;
    localparam int O_NONE = 0, O_DISP = 1, O_NN = 2, O_WR = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, preload;
    logic          disp_en, nn_req, wr_req, err_clr;
    logic [AW-1:0] disp_addr, nn_addr, wr_addr;
    logic [DW-1:0] wr_data;

    logic          disp_valid [2], nn_gnt [2], nn_rvalid [2], wr_gnt [2];
    logic          err_addr [2], ram_we [2];
    logic [AW-1:0] ram_addr [2];
    logic [DW-1:0] ram_wdata [2], ram_rdata [2], rd_data [2];

    logic [DW-1:0] init_img [1024];
    logic [DW-1:0] ref_img  [1024];

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        logic [DW-1:0] mem [1024];
        logic [DW-1:0] rd1_q, rd2_q;

        image_ram_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RD_LAT(gi + 1), .IMG_WORDS(LIMIT)
        ) dut (
            .CLOCK_50  (clk),
            .RST_N     (rst_n),
            .disp_en   (disp_en),
            .disp_addr (disp_addr),
            .disp_valid(disp_valid[gi]),
            .nn_req    (nn_req),
            .nn_addr   (nn_addr),
            .nn_gnt    (nn_gnt[gi]),
            .nn_rvalid (nn_rvalid[gi]),
            .wr_req    (wr_req),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .wr_gnt    (wr_gnt[gi]),
            .err_addr  (err_addr[gi]),
            .err_clr   (err_clr),
            .ram_addr  (ram_addr[gi]),
            .ram_we    (ram_we[gi]),
            .ram_wdata (ram_wdata[gi]),
            .ram_rdata (ram_rdata[gi]),
            .rd_data   (rd_data[gi])
        );

        always @(posedge clk) begin
            if (preload) begin
                for (int i = 0; i < 1024; i++) mem[i] <= init_img[i];
            end else if (ram_we[gi]) begin
                mem[ram_addr[gi]] <= ram_wdata[gi];
            end
            rd1_q <= mem[ram_addr[gi]];
            rd2_q <= rd1_q;
        end
        assign ram_rdata[gi] = (gi == 0) ? rd1_q : rd2_q;
    end

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    // Reference model state: what the outputs must show in the current cycle.
    bit            m_nn_gnt, m_wr_gnt, m_we, m_err, m_last_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            sched_dv [2][NCYC];
    bit            sched_nv [2][NCYC];
    logic [DW-1:0] sched_w  [2][NCYC];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d cyc=%0d observed=%0h expected=%0h", tag, k, cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_nn_gnt = 0; m_wr_gnt = 0; m_we = 0; m_err = 0; m_last_wr = 1;
        m_addr = '0; m_wdata = '0;
        for (int k = 0; k < 2; k++)
            for (int c = cycle + 1; c < NCYC; c++) begin
                sched_dv[k][c] = 0; sched_nv[k][c] = 0;
            end
    endtask

    task automatic chk_all_zero();
        for (int k = 0; k < 2; k++) begin
            chk("rst_disp_valid", k, disp_valid[k], 0);
            chk("rst_nn_gnt",     k, nn_gnt[k],     0);
            chk("rst_nn_rvalid",  k, nn_rvalid[k],  0);
            chk("rst_wr_gnt",     k, wr_gnt[k],     0);
            chk("rst_err_addr",   k, err_addr[k],   0);
            chk("rst_ram_addr",   k, ram_addr[k],   0);
            chk("rst_ram_we",     k, ram_we[k],     0);
            chk("rst_ram_wdata",  k, ram_wdata[k],  0);
        end
    endtask

    task automatic sched(input int kind, input logic [DW-1:0] word);
        for (int k = 0; k < 2; k++) begin
            int c;
            c = cycle + 2 + k;   // request cycle + 1 + RD_LAT
            if (c < NCYC) begin
                if (kind == O_DISP) sched_dv[k][c] = 1;
                else                sched_nv[k][c] = 1;
                sched_w[k][c] = word;
            end
        end
    endtask

    // One clock: predict from the inputs of this cycle, clock, then compare.
    task automatic step();
        bit nn_ok, wr_ok, bad;
        int owner;
        nn_ok = nn_req && !m_nn_gnt;
        wr_ok = wr_req && !m_wr_gnt;
        if (disp_en)              owner = O_DISP;
        else if (nn_ok && wr_ok)  owner = m_last_wr ? O_NN : O_WR;
        else if (nn_ok)           owner = O_NN;
        else if (wr_ok)           owner = O_WR;
        else                      owner = O_NONE;

        bad = 0;
        m_nn_gnt = (owner == O_NN);
        m_wr_gnt = (owner == O_WR);
        m_we = 0;
        case (owner)
            O_DISP: begin
                if (int'(disp_addr) >= LIMIT) bad = 1;
                else begin
                    m_addr = disp_addr;
                    sched(O_DISP, ref_img[disp_addr]);
                end
            end
            O_NN: begin
                bad = (int'(nn_addr) >= LIMIT);
                m_addr = nn_addr;
                sched(O_NN, bad ? 8'h00 : ref_img[nn_addr]);
                m_last_wr = 0;
            end
            O_WR: begin
                bad = (int'(wr_addr) >= LIMIT);
                m_addr = wr_addr;
                m_wdata = wr_data;
                m_we = !bad;
                if (!bad) ref_img[wr_addr] = wr_data;
                m_last_wr = 1;
            end
            default: ;
        endcase
        m_err = bad || (m_err && !err_clr);

        @(posedge clk);
        #1;
        cycle++;
        for (int k = 0; k < 2; k++) begin
            chk("nn_gnt",     k, nn_gnt[k],     m_nn_gnt);
            chk("wr_gnt",     k, wr_gnt[k],     m_wr_gnt);
            chk("ram_we",     k, ram_we[k],     m_we);
            chk("ram_addr",   k, ram_addr[k],   m_addr);
            chk("err_addr",   k, err_addr[k],   m_err);
            chk("disp_valid", k, disp_valid[k], sched_dv[k][cycle]);
            chk("nn_rvalid",  k, nn_rvalid[k],  sched_nv[k][cycle]);
            if (m_we) chk("ram_wdata", k, ram_wdata[k], m_wdata);
            if (sched_dv[k][cycle] || sched_nv[k][cycle])
                chk("rd_data", k, rd_data[k], sched_w[k][cycle]);
        end
        // Requesters drop their request once they see the grant.
        if (owner == O_NN) nn_req = 0;
        if (owner == O_WR) wr_req = 0;
        err_clr = 0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(784, 1023));
        return AW'($urandom_range(0, 783));
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; preload = 0;
        disp_en = 0; disp_addr = '0; nn_req = 0; nn_addr = '0;
        wr_req = 0; wr_addr = '0; wr_data = '0; err_clr = 0;
        for (int i = 0; i < 1024; i++)
            init_img[i] = (i < LIMIT) ? DW'($urandom_range(0, 255)) : 8'hFF;
        init_img[5] = 8'hA7; init_img[10] = 8'h5D; init_img[20] = 8'hC2;
        for (int i = 0; i < 1024; i++) ref_img[i] = init_img[i];

        #2 chk_all_zero();
        @(negedge clk); preload = 1;
        @(negedge clk); preload = 0;
        @(negedge clk); rst_n = 1;
        cycle = 0;
        model_reset();

        // Display holds the RAM for 10 cycles; NN then WR get the next slots.
        disp_en = 1; nn_req = 1; nn_addr = 10'd50; wr_req = 1; wr_addr = 10'd60; wr_data = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            disp_addr = AW'(100 + i);
            step();
        end
        disp_en = 0;
        repeat (4) step();

        // Lone NN read of address 5.
        nn_req = 1; nn_addr = 10'd5;
        repeat (4) step();

        // Write the last pixel, then read it back.
        wr_req = 1; wr_addr = 10'd783; wr_data = 8'h3C;
        step();
        nn_req = 1; nn_addr = 10'd783;
        repeat (4) step();

        // Out-of-range NN read, clear, then set-wins-over-clear.
        nn_req = 1; nn_addr = 10'd784;
        step(); step();
        err_clr = 1; step();
        wr_req = 1; wr_addr = 10'd900; wr_data = 8'h11;
        step(); step();
        err_clr = 1; wr_req = 1; wr_addr = 10'd901;
        step();
        disp_en = 1; disp_addr = 10'd1000; err_clr = 1;
        step();
        disp_en = 0;
        repeat (4) step();

        // Interleaved display and NN reads.
        for (int i = 0; i < 3; i++) begin
            disp_en = 1; disp_addr = 10'd10; step();
            disp_en = 0; nn_req = 1; nn_addr = 10'd20; step();
        end
        repeat (4) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            disp_en = ($urandom_range(0, 9) < 4);
            disp_addr = rand_addr();
            if (!nn_req && $urandom_range(0, 2) == 0) begin
                nn_req = 1; nn_addr = rand_addr();
            end
            if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req = 1; wr_addr = rand_addr(); wr_data = DW'($urandom_range(0, 255));
            end
            err_clr = ($urandom_range(0, 9) == 0);
            step();
        end
        disp_en = 0; nn_req = 0; wr_req = 0;
        repeat (4) step();

        // Reset while a display read and an NN read are in flight.
        disp_en = 1; disp_addr = 10'd30; step();
        disp_en = 0; nn_req = 1; nn_addr = 10'd40; step();
        nn_req = 0;
        #2 rst_n = 0;
        #1 chk_all_zero();
        model_reset();
        @(posedge clk); #1 cycle++;
        chk_all_zero();
        @(negedge clk); rst_n = 1;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
